// File: rtl/debug_capture_pkg.sv
// Shared types and status-byte layout for the debug capture buffer.
// The status byte is consumed verbatim by the SPI debug8 register.
package debug_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  localparam logic [3:0] STATUS_SIG     = 4'h5;
  localparam int         STAT_STATE_LSB = 6;
  localparam int         STAT_OVF       = 5;
  localparam int         STAT_RD_SEEN   = 4;

  // Fixed signature nibble in the low bits lets the host check that the readback path is alive.
  function automatic logic [7:0] pack_status(state_e st, logic ovf, logic rd_seen);
    logic [7:0] s;
    s                         = '0;
    s[3:0]                    = STATUS_SIG;
    s[STAT_RD_SEEN]           = rd_seen;
    s[STAT_OVF]               = ovf;
    s[STAT_STATE_LSB +: 2]    = st;
    return s;
  endfunction

endpackage

// File: rtl/debug_capture_buffer_if.sv
// Capture-side and SPI-readback signals for the debug capture buffer.
// master = host/SPI/pipeline tap driving the buffer, slave = the buffer itself.
interface debug_capture_buffer_if #(
  parameter int DATA_WIDTH = 30,
  parameter int ADDR_WIDTH = 18
);
  logic                  arm;
  logic                  frame_start;
  logic                  frame_end;
  logic                  sample_valid;
  logic [DATA_WIDTH-1:0] sample_data;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [ADDR_WIDTH-1:0] sample_count;
  logic [7:0]            status;

  modport master (
    output arm, frame_start, frame_end, sample_valid, sample_data, rd_en, rd_addr,
    input  rd_data, sample_count, status
  );

  modport slave (
    input  arm, frame_start, frame_end, sample_valid, sample_data, rd_en, rd_addr,
    output rd_data, sample_count, status
  );
endinterface

// File: rtl/debug_capture_ram.sv
// Simple dual-port sample RAM: one write port, one enabled registered read port.
// Out-of-range reads return zero; same-address read/write returns the old word.
module debug_capture_ram #(
  parameter int DATA_WIDTH = 30,
  parameter int ADDR_WIDTH = 18,
  parameter int DEPTH      = 1024,
  parameter int IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_we,
  input  logic [IDX_W-1:0]      i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_re,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  w_rd_in_range;

  assign w_rd_in_range = ({1'b0, i_raddr} < (ADDR_WIDTH+1)'(DEPTH));

  // Storage has no reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  r_rdata <= '0;
    else if (i_re) r_rdata <= w_rd_in_range ? r_mem[i_raddr[IDX_W-1:0]] : '0;
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/debug_capture_buffer.sv
// Triggered sample capture into on-chip RAM with an SPI-facing read port and status byte.
// Arm -> wait for frame_start -> store up to DEPTH samples -> hold until re-armed.
module debug_capture_buffer
  import debug_capture_pkg::*;
#(
  parameter int DATA_WIDTH = 30,
  parameter int ADDR_WIDTH = 18,
  parameter int DEPTH      = 1024
) (
  input  logic                  clk,
  input  logic                  reset_n,
  debug_capture_buffer_if.slave bus
);

  localparam int               IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int               CW       = ADDR_WIDTH + 1;
  // One extra count bit so a full buffer at DEPTH == 2**ADDR_WIDTH never aliases to empty.
  localparam logic [CW-1:0]    FULL_CNT = CW'(DEPTH);

  state_e                r_state;
  logic [CW-1:0]         r_count;
  logic                  r_ovf;
  logic                  r_rd_seen;

  logic                  w_full;
  logic                  w_arm_ok;
  logic                  w_wr;
  logic [DATA_WIDTH-1:0] w_rd_data;

  assign w_full   = (r_count == FULL_CNT);
  assign w_arm_ok = bus.arm && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_wr     = bus.sample_valid &&
                    (((r_state == ST_ARMED) && bus.frame_start) ||
                     ((r_state == ST_CAPTURE) && !w_full));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_count   <= '0;
      r_ovf     <= 1'b0;
    end else begin
      if (w_wr) r_count <= r_count + CW'(1);
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (bus.arm) begin
            r_state <= ST_ARMED;
            r_count <= '0;
            r_ovf   <= 1'b0;
          end
        end
        ST_ARMED: begin
          if (bus.frame_start) r_state <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          // The full cycle lingers in CAPTURE for one clk so a late sample can flag overflow.
          if (w_full) begin
            r_state <= ST_DONE;
            if (bus.sample_valid) r_ovf <= 1'b1;
          end else if (bus.frame_end) begin
            r_state <= ST_DONE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      r_rd_seen <= 1'b0;
    else if (bus.rd_en) r_rd_seen <= 1'b1;
    else if (w_arm_ok)  r_rd_seen <= 1'b0;
  end

  debug_capture_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH),
    .IDX_W      (IDX_W)
  ) u_ram (
    .clk     (clk),
    .reset_n (reset_n),
    .i_we    (w_wr),
    .i_waddr (r_count[IDX_W-1:0]),
    .i_wdata (bus.sample_data),
    .i_re    (bus.rd_en),
    .i_raddr (bus.rd_addr),
    .o_rdata (w_rd_data)
  );

  assign bus.rd_data      = w_rd_data;
  assign bus.sample_count = r_count[ADDR_WIDTH-1:0];
  assign bus.status       = pack_status(r_state, r_ovf, r_rd_seen);

endmodule

// File: tb/tb_debug_capture_buffer.sv
// Scoreboard bench: stimulus pushes expected post-edge outputs, a monitor pops and compares.
module tb_debug_capture_buffer;
  localparam int DW    = 30;
  localparam int AW    = 18;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  debug_capture_buffer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  debug_capture_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [AW-1:0] cnt;
    logic [7:0]    st;
    logic [DW-1:0] rd;
    bit            rd_known;
  } exp_t;
  exp_t exp_q[$];
  bit   mon_en = 1'b0;

  // Reference model: state as a plain integer 0..3, RAM as an array with written-flags.
  int            m_state;
  int            m_cnt;
  bit            m_ovf, m_seen;
  logic [DW-1:0] m_mem [DEPTH];
  bit            m_vld [DEPTH];
  logic [DW-1:0] m_rd;
  bit            m_rd_known;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    m_state = 0; m_cnt = 0; m_ovf = 0; m_seen = 0; m_rd = '0; m_rd_known = 1;
    for (int i = 0; i < DEPTH; i++) m_vld[i] = 0;
  endfunction

  function automatic void model_step(bit a, bit fs, bit fe, bit sv, logic [DW-1:0] sd,
                                     bit re, logic [AW-1:0] ra);
    exp_t e;
    if (re) begin
      if (int'(ra) < DEPTH) begin m_rd = m_mem[ra]; m_rd_known = m_vld[ra]; end
      else begin m_rd = '0; m_rd_known = 1; end
    end
    if (m_state == 0 || m_state == 3) begin
      if (a) begin m_state = 1; m_cnt = 0; m_ovf = 0; m_seen = 0; end
    end else if (m_state == 1) begin
      if (fs) begin
        m_state = 2;
        if (sv) begin m_mem[0] = sd; m_vld[0] = 1; m_cnt = 1; end
      end
    end else begin
      if (m_cnt == DEPTH) begin
        m_state = 3;
        if (sv) m_ovf = 1;
      end else begin
        if (sv) begin m_mem[m_cnt] = sd; m_vld[m_cnt] = 1; m_cnt++; end
        if (fe) m_state = 3;
      end
    end
    if (re) m_seen = 1;
    e.cnt      = AW'(m_cnt);
    e.st       = {2'(m_state), m_ovf, m_seen, 4'h5};
    e.rd       = m_rd;
    e.rd_known = m_rd_known;
    exp_q.push_back(e);
  endfunction

  task automatic step(input bit a, input bit fs, input bit fe, input bit sv,
                      input logic [DW-1:0] sd, input bit re, input logic [AW-1:0] ra);
    @(negedge clk);
    bus.arm = a; bus.frame_start = fs; bus.frame_end = fe;
    bus.sample_valid = sv; bus.sample_data = sd; bus.rd_en = re; bus.rd_addr = ra;
    model_step(a, fs, fe, sv, sd, re, ra);
    @(posedge clk);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, '0, 0, '0);
  endtask

  task automatic rd(input logic [AW-1:0] ra);
    step(0, 0, 0, 0, '0, 1, ra);
  endtask

  // Asynchronous reset asserted between edges; outputs must clear without a clock.
  task automatic do_reset();
    @(negedge clk);
    #2;
    mon_en = 0;
    exp_q.delete();
    bus.arm = 0; bus.frame_start = 0; bus.frame_end = 0; bus.sample_valid = 0;
    bus.sample_data = '0; bus.rd_en = 0; bus.rd_addr = '0;
    reset_n = 0;
    #1;
    chk("rst_status", bus.status, 8'h05);
    chk("rst_count", bus.sample_count, 0);
    chk("rst_rd_data", bus.rd_data, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1;
    model_reset();
    mon_en = 1;
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (mon_en && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("mon_count", bus.sample_count, e.cnt);
      chk("mon_status", bus.status, e.st);
      if (e.rd_known) chk("mon_rd_data", bus.rd_data, e.rd);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] d [12];
    logic [DW-1:0] x, y;
    bit a, fs, fe, sv, re;
    logic [AW-1:0] ra;

    bus.arm = 0; bus.frame_start = 0; bus.frame_end = 0; bus.sample_valid = 0;
    bus.sample_data = '0; bus.rd_en = 0; bus.rd_addr = '0;
    model_reset();
    do_reset();

    // Short frame: frame_start with first sample, frame_end with the sixth.
    step(1, 0, 0, 0, '0, 0, '0);
    step(0, 1, 0, 1, 30'h1, 0, '0);
    for (int i = 2; i <= 5; i++) step(0, 0, 0, 1, DW'(i), 0, '0);
    step(0, 0, 1, 1, 30'h6, 0, '0);
    #2;
    chk("t2_count", bus.sample_count, 6);
    chk("t2_state", bus.status[7:6], 2'd3);
    idle();
    for (int i = 0; i < 6; i++) begin
      rd(AW'(i));
      #2 chk("t2_readback", bus.rd_data, i + 1);
    end

    // Overrun: continuous samples for 12 clks into an 8-deep buffer.
    for (int i = 0; i < 12; i++) d[i] = DW'($urandom);
    step(1, 0, 0, 0, '0, 0, '0);
    step(0, 1, 0, 1, d[0], 0, '0);
    for (int i = 1; i < 12; i++) step(0, 0, 0, 1, d[i], 0, '0);
    #2;
    chk("t3_status", bus.status, 8'hE5);
    chk("t3_count", bus.sample_count, DEPTH);
    rd(AW'(7));
    #2 chk("t3_last_word", bus.rd_data, d[7]);

    // Out-of-range reads, hold with rd_en low, rd_seen.
    rd(AW'(DEPTH));
    #2 chk("t4_rd_depth", bus.rd_data, 0);
    rd(AW'(3));
    #2 chk("t4_rd3", bus.rd_data, d[3]);
    rd(18'h3FFFF);
    #2 chk("t4_rd_max", bus.rd_data, 0);
    rd(AW'(3));
    step(0, 0, 0, 0, '0, 0, AW'(5));
    #2 chk("t4_hold", bus.rd_data, d[3]);
    chk("t4_rd_seen", bus.status[4], 1'b1);

    // Re-arm after overflow, new capture overwrites from address 0.
    step(1, 0, 0, 0, '0, 0, '0);
    #2;
    chk("t6_status", bus.status, 8'h45);
    chk("t6_count", bus.sample_count, 0);
    x = DW'($urandom); y = DW'($urandom);
    step(0, 1, 0, 1, x, 0, '0);
    step(0, 0, 0, 1, y, 0, '0);
    step(0, 0, 1, 0, '0, 0, '0);
    rd(AW'(0));
    #2 chk("t6_addr0", bus.rd_data, x);
    rd(AW'(1));
    rd(AW'(2));
    #2 chk("t6_addr2_old", bus.rd_data, d[2]);

    // Ignored controls: sample/frame_start in DONE and IDLE, arm/frame_start in CAPTURE.
    step(0, 0, 0, 1, 30'h3, 0, '0);
    step(0, 1, 0, 1, 30'h4, 0, '0);
    #2;
    chk("t5_done_state", bus.status[7:6], 2'd3);
    chk("t5_done_count", bus.sample_count, 2);
    do_reset();
    step(0, 1, 0, 1, 30'h7, 0, '0);
    step(0, 0, 0, 1, 30'h8, 0, '0);
    #2;
    chk("t5_idle_state", bus.status[7:6], 2'd0);
    step(1, 0, 0, 0, '0, 0, '0);
    step(0, 1, 0, 1, 30'h11, 0, '0);
    step(1, 0, 0, 1, 30'h12, 0, '0);
    step(0, 1, 0, 1, 30'h13, 0, '0);
    #2;
    chk("t5_cap_state", bus.status[7:6], 2'd2);
    chk("t5_cap_count", bus.sample_count, 3);
    rd(AW'(2));

    // Reset in the middle of a capture.
    do_reset();

    // Randomized traffic checked entirely by the scoreboard.
    for (int n = 0; n < 400; n++) begin
      a  = (m_state != 1) && ($urandom_range(0, 11) == 0);
      fs = ($urandom_range(0, 5) == 0);
      fe = ($urandom_range(0, 14) == 0);
      sv = $urandom_range(0, 1) == 1;
      re = !a && ($urandom_range(0, 2) == 0);
      ra = ($urandom_range(0, 4) == 0) ? AW'($urandom) : AW'($urandom_range(0, DEPTH + 1));
      step(a, fs, fe, sv, DW'($urandom), re, ra);
    end

    idle();
    idle();
    #3;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
